scaler_h_ctrl: RTL and testbench

Configuration and sequencing controller for the horizontal scaler datapath. It converts a requested input/output line width pair into the 4.12 fixed-point `scale_step` the scaler consumes, using an iterative divider. It applies the new step only at a frame boundary so a frame is never scaled with mixed ratios. It also post-processes the scaler output stream, clipping every line to exactly the configured output width and flagging short lines.

---
 rtl/scaler_pkg.sv | 12 +
 rtl/scaler_step_div.sv | 55 +++++
 rtl/scaler_h_ctrl.sv | 146 ++++++++++++++
 tb/tb_scaler_h_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/scaler_pkg.sv
// Shared constants and FSM type for the horizontal scaler controller.
package scaler_pkg;

  localparam int unsigned STEP_W     = 16;
  localparam int unsigned STEP_FRAC  = 12;
  localparam int unsigned PIXEL_STEP = 1 << STEP_FRAC;
  localparam int unsigned MAX_RATIO  = 16;
  localparam int unsigned DIVD_W     = 24;

  typedef enum logic [1:0] {IDLE, CHECK, DIV, PEND} ctrl_state_e;

endpackage

// File: rtl/scaler_step_div.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first, DIVD_W cycles.
module scaler_step_div
  import scaler_pkg::*;
#(
  parameter int unsigned WIDTH_BITS = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVD_W-1:0]     dividend,
  input  logic [WIDTH_BITS-1:0] divisor,
  output logic [DIVD_W-1:0]     quotient,
  output logic                  done
);

  localparam int unsigned CNT_W = $clog2(DIVD_W + 1);

  logic [WIDTH_BITS-1:0] r_rem;
  logic [WIDTH_BITS-1:0] r_dvs;
  logic [CNT_W-1:0]      r_cnt;
  logic [WIDTH_BITS:0]   w_shift;
  logic [WIDTH_BITS+1:0] w_diff;
  logic                  w_fit;

  // Dividend bits leave the top of the quotient register as quotient bits enter the bottom.
  always_comb begin
    w_shift = {r_rem, quotient[DIVD_W-1]};
    w_diff  = {1'b0, w_shift} - {2'b00, r_dvs};
    w_fit   = ~w_diff[WIDTH_BITS+1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_dvs    <= '0;
      r_cnt    <= '0;
      quotient <= '0;
      done     <= 1'b0;
    end else if (start) begin
      r_rem    <= '0;
      r_dvs    <= divisor;
      r_cnt    <= CNT_W'(DIVD_W);
      quotient <= dividend;
      done     <= 1'b0;
    end else if (r_cnt != '0) begin
      r_rem    <= w_fit ? WIDTH_BITS'(w_diff) : WIDTH_BITS'(w_shift);
      quotient <= {quotient[DIVD_W-2:0], w_fit};
      r_cnt    <= r_cnt - CNT_W'(1);
      done     <= (r_cnt == CNT_W'(1));
    end else begin
      done     <= 1'b0;
    end
  end

endmodule

// File: rtl/scaler_h_ctrl.sv
// Horizontal scaler controller: step computation, frame-aligned step update,
// and output line clipping with short-line detection.
module scaler_h_ctrl
  import scaler_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned WIDTH_BITS = 12,
  parameter int unsigned PIXEL_STEP = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH_BITS-1:0] cfg_in_width,
  input  logic [WIDTH_BITS-1:0] cfg_out_width,
  input  logic                  cfg_wr,
  output logic                  cfg_busy,
  output logic                  cfg_err,
  output logic [STEP_W-1:0]     scale_step,
  input  logic                  vs_i,
  input  logic [DATA_WIDTH-1:0] di_i,
  input  logic                  de_i,
  input  logic                  hs_i,
  input  logic                  vs_s_i,
  output logic [DATA_WIDTH-1:0] do_o,
  output logic                  de_o,
  output logic                  hs_o,
  output logic                  vs_o,
  output logic                  short_line,
  input  logic                  err_clr
);

  localparam int unsigned LIM_W = WIDTH_BITS + 4;
  localparam int unsigned CNT_W = WIDTH_BITS + 1;

  ctrl_state_e           r_state;
  ctrl_state_e           w_next;
  logic [WIDTH_BITS-1:0] r_in_w;
  logic [WIDTH_BITS-1:0] r_out_w;
  logic [WIDTH_BITS-1:0] r_act_w;
  logic                  r_vs_d;
  logic [CNT_W-1:0]      r_pix_cnt;
  logic                  w_vs_rise;
  logic                  w_bad;
  logic                  w_start;
  logic                  w_err_set;
  logic                  w_load;
  logic                  w_div_done;
  logic                  w_short;
  logic [DIVD_W-1:0]     w_dividend;
  logic [DIVD_W-1:0]     w_quot;

  assign w_vs_rise  = vs_i & ~r_vs_d;
  assign w_dividend = DIVD_W'(cfg_in_width) << STEP_FRAC;
  // Ratio limit keeps the quotient inside the 4.12 step range.
  assign w_bad = (r_in_w == '0) || (r_out_w == '0) ||
                 (LIM_W'(r_in_w) >= LIM_W'(r_out_w) * LIM_W'(MAX_RATIO));

  scaler_step_div #(.WIDTH_BITS(WIDTH_BITS)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_start),
    .dividend (w_dividend),
    .divisor  (cfg_out_width),
    .quotient (w_quot),
    .done     (w_div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (cfg_wr) w_next = CHECK;
      CHECK:   w_next = w_bad ? IDLE : DIV;
      DIV:     if (w_div_done) w_next = PEND;
      PEND:    if (w_vs_rise) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_start   = 1'b0;
    w_err_set = 1'b0;
    w_load    = 1'b0;
    case (r_state)
      IDLE:    w_start   = cfg_wr;
      CHECK:   w_err_set = w_bad;
      PEND:    w_load    = w_vs_rise;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_w     <= '0;
      r_out_w    <= '0;
      r_act_w    <= '1;
      r_vs_d     <= 1'b0;
      scale_step <= STEP_W'(PIXEL_STEP);
      cfg_busy   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      r_vs_d   <= vs_i;
      cfg_busy <= (w_next != IDLE);
      if (w_start) begin
        r_in_w  <= cfg_in_width;
        r_out_w <= cfg_out_width;
      end
      if (w_load) begin
        scale_step <= STEP_W'(w_quot);
        r_act_w    <= r_out_w;
      end
      if (w_err_set)    cfg_err <= 1'b1;
      else if (err_clr) cfg_err <= 1'b0;
    end
  end

  // hs_o is the previous hs_i sample, so it doubles as the edge detector history.
  assign w_short = hs_i && !hs_o && (r_pix_cnt != '0) &&
                   (r_pix_cnt < CNT_W'(r_act_w));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pix_cnt  <= '0;
      do_o       <= '0;
      de_o       <= 1'b0;
      hs_o       <= 1'b0;
      vs_o       <= 1'b0;
      short_line <= 1'b0;
    end else begin
      hs_o <= hs_i;
      vs_o <= vs_s_i;
      if (hs_i || vs_s_i)
        r_pix_cnt <= '0;
      else if (de_i && (r_pix_cnt != '1))
        r_pix_cnt <= r_pix_cnt + CNT_W'(1);
      de_o <= de_i && (r_pix_cnt < CNT_W'(r_act_w));
      if (de_i) do_o <= di_i;
      if (w_short)      short_line <= 1'b1;
      else if (err_clr) short_line <= 1'b0;
    end
  end

endmodule

// File: tb/tb_scaler_h_ctrl.sv
// Randomized self-checking bench for scaler_h_ctrl against a ratio/line-length model.
module tb_scaler_h_ctrl;
  import scaler_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned WB = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [WB-1:0] cfg_in_width;
  logic [WB-1:0] cfg_out_width;
  logic          cfg_wr;
  logic          cfg_busy;
  logic          cfg_err;
  logic [STEP_W-1:0] scale_step;
  logic          vs_i;
  logic [DW-1:0] di_i;
  logic          de_i;
  logic          hs_i;
  logic          vs_s_i;
  logic [DW-1:0] do_o;
  logic          de_o;
  logic          hs_o;
  logic          vs_o;
  logic          short_line;
  logic          err_clr;

  int n_checks = 0;
  int n_errors = 0;
  int unsigned m_step = PIXEL_STEP;
  int unsigned m_act  = 4095;
  logic [DW-1:0] got_q[$];

  scaler_h_ctrl #(.DATA_WIDTH(DW), .WIDTH_BITS(WB), .PIXEL_STEP(4096)) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_in_width  (cfg_in_width),
    .cfg_out_width (cfg_out_width),
    .cfg_wr        (cfg_wr),
    .cfg_busy      (cfg_busy),
    .cfg_err       (cfg_err),
    .scale_step    (scale_step),
    .vs_i          (vs_i),
    .di_i          (di_i),
    .de_i          (de_i),
    .hs_i          (hs_i),
    .vs_s_i        (vs_s_i),
    .do_o          (do_o),
    .de_o          (de_o),
    .hs_o          (hs_o),
    .vs_o          (vs_o),
    .short_line    (short_line),
    .err_clr       (err_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (de_o) got_q.push_back(do_o);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_req(input int unsigned in_w, input int unsigned out_w,
                         input int unsigned vs_at, input bit extra_wr);
    bit bad;
    int unsigned exp_step;
    int unsigned cyc;
    bad      = (in_w == 0) || (out_w == 0) || (in_w >= MAX_RATIO * out_w);
    exp_step = bad ? m_step : (in_w * PIXEL_STEP) / out_w;
    cfg_in_width  = WB'(in_w);
    cfg_out_width = WB'(out_w);
    cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    cyc = 1;
    chk("busy_rise", 32'(cfg_busy), 1);
    if (bad) begin
      tick();
      chk("err_set", 32'(cfg_err), 1);
      chk("busy_after_err", 32'(cfg_busy), 0);
      chk("step_kept_on_err", 32'(scale_step), m_step);
      return;
    end
    while (cyc < vs_at) begin
      cfg_wr = extra_wr && (cyc == 5);
      if (cyc == 5) begin
        cfg_in_width  = WB'(100);
        cfg_out_width = WB'(90);
      end
      vs_i = (cyc == 10) || (cyc == 11);
      hs_i = (cyc == 15) || (cyc == 30);
      tick();
      cyc++;
    end
    hs_i = 1'b0;
    chk("step_held", 32'(scale_step), m_step);
    chk("busy_pend", 32'(cfg_busy), 1);
    vs_i = 1'b1;
    tick();
    vs_i = 1'b0;
    chk("step_applied", 32'(scale_step), exp_step);
    chk("busy_done", 32'(cfg_busy), 0);
    m_step = exp_step;
    m_act  = out_w;
  endtask

  task automatic run_line(input int unsigned n);
    logic [DW-1:0] px[$];
    int unsigned k;
    bit exp_short;
    hs_i = 1'b1; tick(); tick();
    hs_i = 1'b0; tick();
    err_clr = 1'b1; tick();
    err_clr = 1'b0; tick();
    chk("flags_cleared", 32'(short_line), 0);
    got_q.delete();
    for (int unsigned i = 0; i < n; i++) begin
      di_i = DW'($urandom);
      px.push_back(di_i);
      de_i = 1'b1;
      tick();
    end
    de_i = 1'b0;
    tick(); tick();
    k = (n < m_act) ? n : m_act;
    exp_short = (n != 0) && (n < m_act);
    chk("de_o_count", got_q.size(), k);
    if (k > 0) begin
      chk("first_px", 32'(got_q[0]), 32'(px[0]));
      chk("last_px", 32'(got_q[k-1]), 32'(px[k-1]));
    end
    hs_i = 1'b1;
    tick();
    chk("hs_o_delay", 32'(hs_o), 1);
    hs_i = 1'b0;
    tick(); tick();
    chk("short_line", 32'(short_line), 32'(exp_short));
  endtask

  initial begin
    rst = 1'b1;
    cfg_in_width = '0; cfg_out_width = '0; cfg_wr = 1'b0;
    vs_i = 1'b0; di_i = '0; de_i = 1'b0; hs_i = 1'b0; vs_s_i = 1'b0; err_clr = 1'b0;
    tick(); tick();
    chk("rst_step", 32'(scale_step), PIXEL_STEP);
    chk("rst_busy", 32'(cfg_busy), 0);
    chk("rst_err", 32'(cfg_err), 0);
    chk("rst_short", 32'(short_line), 0);
    chk("rst_de_o", 32'(de_o), 0);
    chk("rst_do_o", 32'(do_o), 0);
    rst = 1'b0;
    tick();

    run_line(10);
    cfg_req(1920, 960, 26, 1'b0);
    cfg_req(1280, 960, 40, 1'b1);
    cfg_req(1024, 64, 0, 1'b0);
    cfg_req(100, 0, 0, 1'b0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("err_cleared", 32'(cfg_err), 0);
    run_line(965);
    run_line(950);
    run_line(0);

    repeat (4) begin
      cfg_req($urandom_range(4095, 1), $urandom_range(1000, 16),
              $urandom_range(45, 26), 1'($urandom_range(1, 0)));
      run_line(m_act + $urandom_range(10, 0) - 5);
      run_line($urandom_range(m_act, 1));
    end

    // Reset in the middle of a division must discard the pending request.
    cfg_req(1024, 64, 0, 1'b0);
    cfg_in_width = WB'(1280); cfg_out_width = WB'(960); cfg_wr = 1'b1;
    tick();
    cfg_wr = 1'b0;
    for (int unsigned c = 1; c < 10; c++) begin
      de_i = (c == 3); di_i = 8'h5A;
      hs_i = (c == 9); vs_s_i = (c == 9);
      tick();
    end
    chk("pre_rst_busy", 32'(cfg_busy), 1);
    chk("pre_rst_do_o", 32'(do_o), 32'h5A);
    chk("pre_rst_hs_o", 32'(hs_o), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_step", 32'(scale_step), PIXEL_STEP);
    chk("mid_rst_busy", 32'(cfg_busy), 0);
    chk("mid_rst_err", 32'(cfg_err), 0);
    chk("mid_rst_do_o", 32'(do_o), 0);
    chk("mid_rst_hs_o", 32'(hs_o), 0);
    chk("mid_rst_vs_o", 32'(vs_o), 0);
    hs_i = 1'b0; vs_s_i = 1'b0; de_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
    m_step = PIXEL_STEP;
    m_act  = 4095;
    repeat (30) tick();
    vs_i = 1'b1; tick(); vs_i = 1'b0; tick();
    chk("post_rst_step", 32'(scale_step), m_step);
    chk("post_rst_busy", 32'(cfg_busy), 0);
    run_line(20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
